unified_sram_arb: RTL

Arbiter and read-return sequencer that lets the IF-stage instruction fetch and the ME-stage load/store port share one single-ported unified SRAM. Each cycle it grants at most one requester, drives the SRAM port and tracks every in-flight read through a tag pipeline matching the SRAM read latency. It then steers the returned data to the requester that issued the read. Data requests have priority, with a starvation counter that guarantees fetch forward progress.

---
 rtl/unified_sram_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/unified_sram_arb.sv
// unified_sram_arb
// Shares one single-ported unified SRAM between the IF-stage fetch port and
// the ME-stage load/store port. At most one requester is granted per cycle;
// the grant is combinational and the winner's fields drive the SRAM port
// directly. Reads are tracked through a tag pipeline whose depth equals the
// SRAM read latency, so each returned word is steered to the port that issued
// the read. Data has priority, but a starvation counter forces a fetch grant
// after MAX_STARVE consecutive denied fetch cycles.
//
// Ports
//   clk, resetn                  clock, async active-low reset
//   inst_req/inst_addr           fetch request (held until inst_ready)
//   inst_ready                   fetch accepted this cycle
//   inst_rvalid/inst_rdata       fetch read return
//   data_req/data_we/data_addr/data_wdata
//                                load/store request (data_we==0 -> load)
//   data_ready                   load/store accepted this cycle
//   data_rvalid/data_rdata       load read return
//   sram_en/sram_we/sram_addr/sram_wdata
//                                SRAM command port
//   sram_rdata                   SRAM read data, RD_LAT cycles after a read
module unified_sram_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ready,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ready,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  logic [3:0]        r_starve;
  // Tag pipeline: vld_pipe marks an in-flight read, port_pipe its owner
  // (1 = data port, 0 = fetch port).
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [RD_LAT-1:0] r_port_pipe;

  logic w_force;
  logic w_inst_gnt;
  logic w_data_gnt;
  logic w_rd;
  logic w_ret_vld;
  logic w_ret_data;

  // Grants are gated by resetn so nothing reaches the SRAM while in reset.
  always_comb begin
    w_force    = inst_req && (r_starve == STARVE_MAX);
    w_inst_gnt = resetn && inst_req && (w_force || !data_req);
    w_data_gnt = resetn && data_req && !w_force;
    w_rd       = w_inst_gnt || (w_data_gnt && (data_we == '0));
  end

  assign inst_ready = w_inst_gnt;
  assign data_ready = w_data_gnt;
  assign sram_en    = w_inst_gnt | w_data_gnt;

  always_comb begin
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_data_gnt) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (w_inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  // Counts consecutive cycles in which fetch asked but lost; saturates so the
  // forced-fetch condition holds until the fetch is actually granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if (!inst_req || w_inst_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Fixed-depth shift; never stalls, so the last stage lines up exactly with
  // sram_rdata for the read issued RD_LAT cycles earlier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_pipe  <= '0;
      r_port_pipe <= '0;
    end else begin
      r_vld_pipe[0]  <= w_rd;
      r_port_pipe[0] <= w_rd && w_data_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_port_pipe[i] <= r_port_pipe[i-1];
      end
    end
  end

  assign w_ret_vld  = r_vld_pipe[RD_LAT-1];
  assign w_ret_data = r_port_pipe[RD_LAT-1];

  assign inst_rvalid = w_ret_vld && !w_ret_data;
  assign data_rvalid = w_ret_vld && w_ret_data;
  assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
  assign data_rdata  = data_rvalid ? sram_rdata : '0;

endmodule
